// File: rtl/fpu_ctrl_pkg.sv
// Shared constants and types for the fpu issue arbiter and its response FIFOs.
package fpu_ctrl_pkg;

    localparam int NUM_REQ = 2;

    localparam logic [1:0] FPU_ADD  = 2'b00;
    localparam logic [1:0] FPU_SUB  = 2'b01;
    localparam logic [1:0] FPU_IDLE = 2'b11;

    typedef struct packed {
        logic vld;
        logic tag;
    } inflight_t;

endpackage

// File: rtl/fpu_rsp_fifo.sv
// 32-bit synchronous response FIFO, registered head (no fall-through), push and pop legal together.
// Never pushed when full by construction of the issue credits; an overflow trips the assertion.
module fpu_rsp_fifo #(
    parameter int DEPTH = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        push_i,
    input  logic [31:0] push_dat_i,
    input  logic        pop_i,
    output logic [31:0] pop_dat_o,
    output logic [3:0]  count_o,
    output logic        empty_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [31:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_q, wr_d;
    logic [AW-1:0] rd_q, rd_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          do_push, do_pop, full;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    always_comb begin
        full    = (cnt_q == 4'(DEPTH));
        do_pop  = pop_i && (cnt_q != 4'd0);
        do_push = push_i && (!full || do_pop);
        wr_d    = do_push ? ptr_inc(wr_q) : wr_q;
        rd_d    = do_pop ? ptr_inc(rd_q) : rd_q;
        cnt_d   = cnt_q + {3'b000, do_push} - {3'b000, do_pop};
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_q] <= push_dat_i;
        end
    end

    always_ff @(posedge clk_i) begin
        assert (rst_i || !(push_i && full && !pop_i));
    end

    assign pop_dat_o = mem_q[rd_q];
    assign count_o   = cnt_q;
    assign empty_o   = (cnt_q == 4'd0);

endmodule

// File: rtl/fpu_issue_arbiter.sv
// Round-robin sharing of one fixed-latency fpu between two requesters; result lands in FIFO[tag]
// FPU_LAT cycles after issue, visible one cycle later. A requester is stalled while its credits are used up.
module fpu_issue_arbiter
    import fpu_ctrl_pkg::*;
#(
    parameter int FPU_LAT   = 1,
    parameter int RSP_DEPTH = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [1:0]  req_valid_i,
    output logic [1:0]  req_ready_o,
    input  logic [1:0]  req_sub_i,
    input  logic [63:0] req_op_a_i,
    input  logic [63:0] req_op_b_i,
    output logic [1:0]  rsp_valid_o,
    input  logic [1:0]  rsp_ready_i,
    output logic [63:0] rsp_data_o,
    output logic [31:0] fpu_op_a_o,
    output logic [31:0] fpu_op_b_o,
    output logic [1:0]  fpu_opcode_o,
    input  logic [31:0] fpu_result_i,
    output logic        busy_o
);

    logic               ptr_q, ptr_d;
    logic [3:0]         inflight_q [NUM_REQ];
    logic [3:0]         inflight_d [NUM_REQ];
    inflight_t          pipe_q [FPU_LAT];
    inflight_t          pipe_d [FPU_LAT];
    inflight_t          ret;
    logic [31:0]        op_a_q, op_b_q;
    logic               busy_q, busy_d;
    logic [NUM_REQ-1:0] elig, qual, grant, ret_push, rsp_pop, fifo_empty;
    logic               issue, gnt_idx;
    logic [3:0]         fifo_cnt [NUM_REQ];
    logic [31:0]        fifo_dat [NUM_REQ];

    // Credits: an op holds one slot from issue until its response is popped.
    always_comb begin
        for (int n = 0; n < NUM_REQ; n++) begin
            elig[n] = ({1'b0, inflight_q[n]} + {1'b0, fifo_cnt[n]}) < 5'(RSP_DEPTH);
        end
        qual  = req_valid_i & elig & {NUM_REQ{~rst_i}};
        grant = qual;
        if (&qual) begin
            grant = ptr_q ? 2'b10 : 2'b01;
        end
        issue   = |grant;
        gnt_idx = grant[1];
        ptr_d   = issue ? ~gnt_idx : ptr_q;
    end

    assign req_ready_o  = grant;
    assign fpu_op_a_o   = issue ? req_op_a_i[{gnt_idx, 5'd0} +: 32] : op_a_q;
    assign fpu_op_b_o   = issue ? req_op_b_i[{gnt_idx, 5'd0} +: 32] : op_b_q;
    assign fpu_opcode_o = issue ? {1'b0, req_sub_i[gnt_idx]} : FPU_IDLE;

    assign ret         = pipe_q[FPU_LAT-1];
    assign rsp_valid_o = ~fifo_empty & {NUM_REQ{~rst_i}};
    assign busy_o      = busy_q;

    always_comb begin
        pipe_d[0].vld = issue;
        pipe_d[0].tag = gnt_idx;
        for (int i = 1; i < FPU_LAT; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
        busy_d = 1'b0;
        for (int n = 0; n < NUM_REQ; n++) begin
            ret_push[n]   = ret.vld && (ret.tag == 1'(n));
            rsp_pop[n]    = rsp_valid_o[n] && rsp_ready_i[n];
            inflight_d[n] = inflight_q[n] + {3'b000, issue && (gnt_idx == 1'(n))}
                            - {3'b000, ret_push[n]};
            busy_d = busy_d || (inflight_d[n] != 4'd0)
                     || ((fifo_cnt[n] + {3'b000, ret_push[n]} - {3'b000, rsp_pop[n]}) != 4'd0);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q  <= 1'b0;
            op_a_q <= '0;
            op_b_q <= '0;
            busy_q <= 1'b0;
            for (int n = 0; n < NUM_REQ; n++) begin
                inflight_q[n] <= '0;
            end
            for (int i = 0; i < FPU_LAT; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            ptr_q  <= ptr_d;
            op_a_q <= fpu_op_a_o;
            op_b_q <= fpu_op_b_o;
            busy_q <= busy_d;
            for (int n = 0; n < NUM_REQ; n++) begin
                inflight_q[n] <= inflight_d[n];
            end
            for (int i = 0; i < FPU_LAT; i++) begin
                pipe_q[i] <= pipe_d[i];
            end
        end
    end

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_rsp
        fpu_rsp_fifo #(
            .DEPTH(RSP_DEPTH)
        ) u_fifo (
            .clk_i      (clk_i),
            .rst_i      (rst_i),
            .push_i     (ret_push[g]),
            .push_dat_i (fpu_result_i),
            .pop_i      (rsp_pop[g]),
            .pop_dat_o  (fifo_dat[g]),
            .count_o    (fifo_cnt[g]),
            .empty_o    (fifo_empty[g])
        );
        assign rsp_data_o[32*g +: 32] = fifo_dat[g];
    end

endmodule

// File: tb/tb_fpu_issue_arbiter.sv
// Bench for fpu_issue_arbiter: behavioural fpu, outstanding-credit reference model and per-requester scoreboard.
module tb_fpu_issue_arbiter;
    import fpu_ctrl_pkg::*;

    localparam int LAT   = 3;
    localparam int DEPTH = 2;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [1:0]  req_valid_i, req_ready_o, req_sub_i;
    logic [63:0] req_op_a_i, req_op_b_i;
    logic [1:0]  rsp_valid_o, rsp_ready_i;
    logic [63:0] rsp_data_o;
    logic [31:0] fpu_op_a_o, fpu_op_b_o, fpu_result_i;
    logic [1:0]  fpu_opcode_o;
    logic        busy_o;

    always #5 clk_i = ~clk_i;

    fpu_issue_arbiter #(.FPU_LAT(LAT), .RSP_DEPTH(DEPTH)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_sub_i    (req_sub_i),
        .req_op_a_i   (req_op_a_i),
        .req_op_b_i   (req_op_b_i),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_ready_i  (rsp_ready_i),
        .rsp_data_o   (rsp_data_o),
        .fpu_op_a_o   (fpu_op_a_o),
        .fpu_op_b_o   (fpu_op_b_o),
        .fpu_opcode_o (fpu_opcode_o),
        .fpu_result_i (fpu_result_i),
        .busy_o       (busy_o)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @cycle %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    // Single-precision <-> real for normal numbers and zero; all operands are small integers, so results are exact.
    function automatic real sp2r(input logic [31:0] x);
        logic [63:0] d;
        logic [10:0] e;
        if (x[30:0] == 31'd0) return 0.0;
        e = {3'b000, x[30:23]} + 11'd896;
        d = {x[31], e, x[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] r2sp(input real r);
        logic [63:0] d;
        logic [10:0] e;
        if (r == 0.0) return 32'd0;
        d = $realtobits(r);
        e = d[62:52] - 11'd896;
        return {d[63], e[7:0], d[51:29]};
    endfunction

    function automatic logic [31:0] fp_of(input int k);
        return r2sp($itor(k));
    endfunction

    // Fixed-latency fpu: result of the op presented in cycle t appears during cycle t+LAT.
    logic [31:0] fres [LAT];
    always @(posedge clk_i) begin
        case (fpu_opcode_o)
            FPU_ADD: fres[0] <= r2sp(sp2r(fpu_op_a_o) + sp2r(fpu_op_b_o));
            FPU_SUB: fres[0] <= r2sp(sp2r(fpu_op_a_o) - sp2r(fpu_op_b_o));
            default: fres[0] <= 32'hDEAD_BEEF;
        endcase
        for (int i = 1; i < LAT; i++) fres[i] <= fres[i-1];
    end
    assign fpu_result_i = fres[LAT-1];

    typedef struct {
        logic [31:0] d;
        int          due;
    } exp_t;

    exp_t        q [2][$];
    int          outst [2];
    logic        ptr_m;
    logic [31:0] last_a, last_b;

    // Monitor: expected grant from outstanding-credit counts, scoreboard for responses.
    always @(negedge clk_i) begin : mon
        logic [1:0]  qual, eg;
        logic [31:0] a, b, e;
        logic        s, ev;
        int          n;
        if (rst_i) begin
            check("rst_req_ready", req_ready_o, 2'b00);
            check("rst_rsp_valid", rsp_valid_o, 2'b00);
            check("rst_opcode", fpu_opcode_o, FPU_IDLE);
            outst[0] = 0;
            outst[1] = 0;
            ptr_m    = 1'b0;
            last_a   = '0;
            last_b   = '0;
            q[0].delete();
            q[1].delete();
        end else begin
            check("busy", busy_o, (outst[0] + outst[1]) != 0);
            qual = req_valid_i & {outst[1] < DEPTH, outst[0] < DEPTH};
            eg   = (qual == 2'b11) ? (ptr_m ? 2'b10 : 2'b01) : qual;
            check("req_ready", req_ready_o, eg);
            if (eg != 2'b00) begin
                n = eg[1] ? 1 : 0;
                a = req_op_a_i[32*n +: 32];
                b = req_op_b_i[32*n +: 32];
                s = req_sub_i[n];
                check("issue_opcode", fpu_opcode_o, {1'b0, s});
                check("issue_op_a", fpu_op_a_o, a);
                check("issue_op_b", fpu_op_b_o, b);
                e = s ? r2sp(sp2r(a) - sp2r(b)) : r2sp(sp2r(a) + sp2r(b));
                q[n].push_back('{d: e, due: cyc + LAT + 1});
                outst[n]++;
                ptr_m  = (n == 0);
                last_a = a;
                last_b = b;
            end else begin
                check("idle_opcode", fpu_opcode_o, FPU_IDLE);
                check("hold_op_a", fpu_op_a_o, last_a);
                check("hold_op_b", fpu_op_b_o, last_b);
            end
            for (int k = 0; k < 2; k++) begin
                ev = (q[k].size() > 0) && (q[k][0].due <= cyc);
                check("rsp_valid", rsp_valid_o[k], ev);
                if (ev && rsp_ready_i[k]) begin
                    check("rsp_data", rsp_data_o[32*k +: 32], q[k][0].d);
                    void'(q[k].pop_front());
                    outst[k]--;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
    endtask

    task automatic send(input int n, input logic s, input logic [31:0] a, input logic [31:0] b,
                        output int t);
        req_sub_i[n]            = s;
        req_op_a_i[32*n +: 32]  = a;
        req_op_b_i[32*n +: 32]  = b;
        req_valid_i[n]          = 1'b1;
        t = -1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk_i);
            if (req_ready_o[n]) begin
                t = cyc;
                check("send_opcode", fpu_opcode_o, {1'b0, s});
                break;
            end
            tick();
        end
        check("send_accepted", 64'(t >= 0), 64'd1);
        tick();
        req_valid_i[n] = 1'b0;
    endtask

    task automatic wait_rsp(input int n, input logic [31:0] exp_d, output int t);
        t = -1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk_i);
            if (rsp_valid_o[n]) begin
                t = cyc;
                break;
            end
        end
        check("rsp_seen", 64'(t >= 0), 64'd1);
        if (t >= 0) check("rsp_directed_data", rsp_data_o[32*n +: 32], exp_d);
        tick();
    endtask

    task automatic drain();
        int k;
        req_valid_i = 2'b00;
        rsp_ready_i = 2'b11;
        for (k = 0; k < 200; k++) begin
            @(negedge clk_i);
            if (!busy_o && q[0].size() == 0 && q[1].size() == 0) break;
        end
        check("drain_busy", busy_o, 1'b0);
        check("drain_pending", 64'(q[0].size() + q[1].size()), 64'd0);
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int t_iss, t_rsp, acc0;
        logic [1:0] g [4];

        rst_i       = 1'b1;
        req_valid_i = 2'b11;
        req_sub_i   = 2'b00;
        req_op_a_i  = '0;
        req_op_b_i  = '0;
        rsp_ready_i = 2'b11;
        repeat (3) tick();
        rst_i       = 1'b0;
        req_valid_i = 2'b00;
        @(negedge clk_i);
        check("reset_busy", busy_o, 1'b0);
        check("reset_op_a", fpu_op_a_o, 32'd0);
        check("reset_rsp_valid", rsp_valid_o, 2'b00);
        tick();

        // Single ADD, 1.0 + 2.0 on requester 0.
        send(0, 1'b0, 32'h3F80_0000, 32'h4000_0000, t_iss);
        wait_rsp(0, 32'h4040_0000, t_rsp);
        check("add_latency", 64'(t_rsp - t_iss), 64'(LAT + 1));
        @(negedge clk_i);
        check("add_busy_after", busy_o, 1'b0);
        tick();

        // SUB on requester 1, 3.0 - 1.0.
        send(1, 1'b1, 32'h4040_0000, 32'h3F80_0000, t_iss);
        @(negedge clk_i);
        check("sub_opcode_after", fpu_opcode_o, FPU_IDLE);
        wait_rsp(1, 32'h4000_0000, t_rsp);
        drain();

        // Both requesters continuously valid from reset: grants alternate 0,1,0,1.
        do_reset();
        req_op_a_i  = {fp_of(5), fp_of(1)};
        req_op_b_i  = {fp_of(2), fp_of(1)};
        req_sub_i   = 2'b10;
        req_valid_i = 2'b11;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            g[i] = req_ready_o;
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            check("alt_grant", g[i], (i % 2 == 1) ? 2'b10 : 2'b01);
        end
        drain();

        // Backpressure on requester 0 only.
        rsp_ready_i = 2'b10;
        req_valid_i = 2'b11;
        acc0 = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk_i);
            if (req_valid_i[0] && req_ready_o[0]) acc0++;
            tick();
        end
        check("bp_accepts_req0", 64'(acc0), 64'(DEPTH));
        rsp_ready_i = 2'b11;
        repeat (10) tick();
        drain();

        // Reset one cycle after an issue: that op must never produce a response.
        send(0, 1'b0, fp_of(7), fp_of(9), t_iss);
        rst_i = 1'b1;
        tick();
        rst_i       = 1'b0;
        req_valid_i = 2'b11;
        @(negedge clk_i);
        check("post_reset_grant", req_ready_o, 2'b01);
        tick();
        req_valid_i = 2'b00;
        drain();

        // Randomized traffic with random response backpressure.
        for (int i = 0; i < 2500; i++) begin
            req_valid_i = 2'($urandom_range(0, 3));
            req_sub_i   = 2'($urandom_range(0, 3));
            for (int n = 0; n < 2; n++) begin
                req_op_a_i[32*n +: 32] = fp_of(int'($urandom_range(1, 4096)));
                req_op_b_i[32*n +: 32] = fp_of(int'($urandom_range(1, 4096)));
                rsp_ready_i[n]         = ($urandom_range(0, 9) < 7);
            end
            tick();
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
